// File: rtl/matrix_scan_sequencer.sv
// Frame-scan controller: walks a frame buffer column by column, word by word,
// and feeds the LED-matrix output module with command pulses and data words.
module matrix_scan_sequencer #(
  parameter int COLUMNS          = 16,
  parameter int WORDS_PER_COLUMN = 8,
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int ADDR_WIDTH       = (COLUMNS * WORDS_PER_COLUMN > 1) ?
                                   $clog2(COLUMNS * WORDS_PER_COLUMN) : 1
) (
  input  logic                               I_clk,
  input  logic                               I_rst_n,
  input  logic                               I_start,
  input  logic                               I_continuous,
  input  logic                               I_extra_bit,
  output logic                               O_rd_en,
  output logic [ADDR_WIDTH-1:0]              O_rd_addr,
  input  logic [SPI_SIZE*CHANNEL_NUMBER-1:0] I_rd_data,
  output logic [SPI_SIZE*CHANNEL_NUMBER-1:0] O_data_flat,
  output logic                               O_next_image,
  output logic                               O_next_column,
  output logic                               O_next_data,
  output logic                               O_extra_bit,
  input  logic                               I_tx_finish,
  output logic                               O_busy,
  output logic                               O_frame_done,
  output logic [2:0]                         O_dbg_state
);

  localparam int COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;
  localparam int DATA_W = SPI_SIZE * CHANNEL_NUMBER;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_FRAME_END = 3'd6
  } state_t;

  state_t                r_state;
  logic [COL_W-1:0]      r_col;
  logic [WORD_W-1:0]     r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_en;
  logic [DATA_W-1:0]     r_data;
  logic                  r_next_image;
  logic                  r_next_column;
  logic                  r_next_data;
  logic                  r_extra;
  logic                  r_frame_done;

  logic w_word_last;
  logic w_frame_last;

  assign w_word_last  = (r_word == WORD_W'(WORDS_PER_COLUMN - 1));
  assign w_frame_last = w_word_last && (r_col == COL_W'(COLUMNS - 1));

  // Valid/ready contract with the output module: a command is only issued
  // from ISSUE, and the next word is fetched only after I_tx_finish has been
  // observed low (accepted/busy) and then high again (idle).
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_word        <= '0;
      r_addr        <= '0;
      r_rd_en       <= 1'b0;
      r_data        <= '0;
      r_next_image  <= 1'b0;
      r_next_column <= 1'b0;
      r_next_data   <= 1'b0;
      r_extra       <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (I_start && I_tx_finish) begin
            r_extra <= I_extra_bit;
            r_col   <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_rd_en <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_data        <= I_rd_data;
          r_next_image  <= (r_word == '0) && (r_col == '0);
          r_next_column <= (r_word == '0) && (r_col != '0);
          r_next_data   <= (r_word != '0);
          r_state       <= S_ISSUE;
        end
        S_ISSUE: begin
          r_next_image  <= 1'b0;
          r_next_column <= 1'b0;
          r_next_data   <= 1'b0;
          r_state       <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!I_tx_finish) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (I_tx_finish) begin
            if (w_frame_last) begin
              r_frame_done <= 1'b1;
              r_state      <= S_FRAME_END;
            end else begin
              if (w_word_last) begin
                r_word <= '0;
                r_col  <= r_col + COL_W'(1);
              end else begin
                r_word <= r_word + WORD_W'(1);
              end
              r_addr  <= r_addr + ADDR_WIDTH'(1);
              r_rd_en <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_FRAME_END: begin
          r_frame_done <= 1'b0;
          r_col        <= '0;
          r_word       <= '0;
          r_addr       <= '0;
          if (I_continuous) begin
            r_extra <= I_extra_bit;
            r_rd_en <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_rd_en       <= 1'b0;
          r_next_image  <= 1'b0;
          r_next_column <= 1'b0;
          r_next_data   <= 1'b0;
          r_frame_done  <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign O_rd_en       = r_rd_en;
  assign O_rd_addr     = r_addr;
  assign O_data_flat   = r_data;
  assign O_next_image  = r_next_image;
  assign O_next_column = r_next_column;
  assign O_next_data   = r_next_data;
  assign O_extra_bit   = r_extra;
  assign O_frame_done  = r_frame_done;
  assign O_busy        = (r_state != S_IDLE);
  assign O_dbg_state   = r_state;

endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// Bench for matrix_scan_sequencer: buffer and output-module models plus a
// frame-level expected-command scoreboard.
module tb_matrix_scan_sequencer;

  localparam int C      = 2;
  localparam int W      = 2;
  localparam int CH     = 3;
  localparam int SPI    = 8;
  localparam int AW     = 2;
  localparam int DW     = SPI * CH;
  localparam int NWORDS = C * W;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;

  logic          I_clk = 1'b0;
  logic          I_rst_n;
  logic          I_start;
  logic          I_continuous;
  logic          I_extra_bit;
  logic          O_rd_en;
  logic [AW-1:0] O_rd_addr;
  logic [DW-1:0] I_rd_data;
  logic [DW-1:0] O_data_flat;
  logic          O_next_image;
  logic          O_next_column;
  logic          O_next_data;
  logic          O_extra_bit;
  logic          I_tx_finish;
  logic          O_busy;
  logic          O_frame_done;
  logic [2:0]    O_dbg_state;

  matrix_scan_sequencer #(
    .COLUMNS(C), .WORDS_PER_COLUMN(W), .CHANNEL_NUMBER(CH), .SPI_SIZE(SPI)
  ) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_start(I_start),
    .I_continuous(I_continuous), .I_extra_bit(I_extra_bit),
    .O_rd_en(O_rd_en), .O_rd_addr(O_rd_addr), .I_rd_data(I_rd_data),
    .O_data_flat(O_data_flat), .O_next_image(O_next_image),
    .O_next_column(O_next_column), .O_next_data(O_next_data),
    .O_extra_bit(O_extra_bit), .I_tx_finish(I_tx_finish), .O_busy(O_busy),
    .O_frame_done(O_frame_done), .O_dbg_state(O_dbg_state)
  );

  always #5 I_clk = ~I_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;
  int n_done   = 0;
  int exp_done = 0;

  logic [26:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];

  bit stuck      = 1'b0;
  bit force_low  = 1'b0;
  bit fixed_busy = 1'b1;
  int busy_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame buffer: word k holds 0x10+k on every channel, one cycle read latency.
  always @(posedge I_clk) begin
    if (O_rd_en) I_rd_data <= {CH{8'(8'h10 + 8'(O_rd_addr))}};
  end

  // Output module: goes busy after each command pulse, idle otherwise.
  always @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) busy_cnt <= 0;
    else if ((O_next_image || O_next_column || O_next_data) && !stuck)
      busy_cnt <= fixed_busy ? 5 : int'($urandom_range(1, 8));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign I_tx_finish = (busy_cnt == 0) && !force_low;

  // Reference model: command kind and data follow from the word index alone.
  task automatic push_frame(input bit extra);
    logic [1:0] code;
    logic [7:0] d;
    for (int k = 0; k < NWORDS; k++) begin
      if (k == 0) code = 2'd1;
      else if (k % W == 0) code = 2'd2;
      else code = 2'd3;
      d = 8'h10 + 8'(k);
      exp_q.push_back({code, extra, {CH{d}}});
      addr_q.push_back(AW'(k));
    end
  endtask

  always @(negedge I_clk) begin
    int np;
    logic [1:0] code;
    if (I_rst_n) begin
      if (O_rd_en) begin
        if (addr_q.size() == 0) check("rd_unexpected", O_rd_en, 1'b0);
        else check("rd_addr", O_rd_addr, addr_q.pop_front());
      end
      np = int'(O_next_image) + int'(O_next_column) + int'(O_next_data);
      if (np != 0) begin
        n_pulses++;
        check("cmd_onehot", np, 1);
        code = O_next_image ? 2'd1 : (O_next_column ? 2'd2 : 2'd3);
        if (exp_q.size() == 0) check("cmd_unexpected", np, 0);
        else check("cmd", {code, O_extra_bit, O_data_flat}, exp_q.pop_front());
      end
      if (O_frame_done) n_done++;
    end
  end

  task automatic step();
    @(negedge I_clk);
    #1;
  endtask

  task automatic pulse_start();
    I_start = 1'b1;
    @(posedge I_clk);
    #1 I_start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    step();
    while (O_busy && i < max) begin
      step();
      i++;
    end
    check("idle_reached", O_busy, 1'b0);
  endtask

  task automatic wait_pulses(input int target, input int max);
    int i = 0;
    while (n_pulses < target && i < max) begin
      step();
      i++;
    end
    check("pulse_wait", n_pulses, target);
  endtask

  task automatic wait_frames(input int target, input int max);
    int i = 0;
    while (n_done < target && i < max) begin
      step();
      i++;
    end
    check("frame_wait", n_done, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, O_rd_en, 1'b0);
    check({tag, "_addr"}, O_rd_addr, '0);
    check({tag, "_data"}, O_data_flat, '0);
    check({tag, "_cmds"}, {O_next_image, O_next_column, O_next_data}, 3'b000);
    check({tag, "_extra"}, O_extra_bit, 1'b0);
    check({tag, "_busy"}, O_busy, 1'b0);
    check({tag, "_done"}, O_frame_done, 1'b0);
    check({tag, "_state"}, O_dbg_state, 3'd0);
  endtask

  task automatic check_frames_clean(input string tag);
    check({tag, "_frames"}, n_done, exp_done);
    check({tag, "_cmdq"}, exp_q.size(), 0);
    check({tag, "_addrq"}, addr_q.size(), 0);
  endtask

  initial begin
    int p0;
    bit e;
    I_rst_n = 1'b0;
    I_start = 1'b0;
    I_continuous = 1'b0;
    I_extra_bit = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    I_rst_n = 1'b1;
    repeat (2) step();

    // Single frame with exact first-command latency.
    push_frame(1'b0);
    pulse_start();
    step();
    check("lat_fetch_rd", O_rd_en, 1'b1);
    check("lat_fetch_cmd", {O_next_image, O_next_column, O_next_data}, 3'b000);
    step();
    check("lat_latch_cmd", {O_next_image, O_next_column, O_next_data}, 3'b000);
    step();
    check("lat_image", O_next_image, 1'b1);
    exp_done++;
    wait_idle(500);
    check_frames_clean("single");
    fixed_busy = 1'b0;

    // Continuous: two frames, then stop once I_continuous drops.
    push_frame(1'b0);
    push_frame(1'b0);
    I_continuous = 1'b1;
    pulse_start();
    wait_frames(exp_done + 1, 500);
    @(posedge I_clk);
    #1 I_continuous = 1'b0;
    exp_done += 2;
    wait_idle(500);
    check_frames_clean("cont");

    // Start while output module not idle is dropped.
    force_low = 1'b1;
    p0 = n_pulses;
    pulse_start();
    repeat (20) step();
    check("nofin_busy", O_busy, 1'b0);
    check("nofin_pulses", n_pulses, p0);
    force_low = 1'b0;

    // Start while busy is ignored.
    push_frame(1'b0);
    p0 = n_pulses;
    pulse_start();
    wait_pulses(p0 + 1, 100);
    pulse_start();
    repeat (3) step();
    pulse_start();
    exp_done++;
    wait_idle(500);
    repeat (20) step();
    check("busy_start_idle", O_busy, 1'b0);
    check_frames_clean("busy_start");

    // Extra bit latched at frame start, held against later input changes.
    push_frame(1'b1);
    I_extra_bit = 1'b1;
    p0 = n_pulses;
    pulse_start();
    wait_pulses(p0 + 1, 100);
    I_extra_bit = 1'b0;
    exp_done++;
    wait_idle(500);
    check("extra_hold", O_extra_bit, 1'b1);
    check_frames_clean("extra");

    // Output module that never drops tx_finish parks the sequencer.
    stuck = 1'b1;
    push_frame(1'b0);
    p0 = n_pulses;
    pulse_start();
    wait_pulses(p0 + 1, 100);
    repeat (40) step();
    check("stuck_state", O_dbg_state, ST_WAIT_BUSY);
    check("stuck_pulses", n_pulses, p0 + 1);
    check("stuck_busy", O_busy, 1'b1);
    I_rst_n = 1'b0;
    #1;
    check_reset_outputs("stuck_rst");
    exp_q.delete();
    addr_q.delete();
    stuck = 1'b0;
    step();
    I_rst_n = 1'b1;
    step();

    // Reset while waiting for the second word to finish transmitting.
    fixed_busy = 1'b1;
    push_frame(1'b1);
    I_extra_bit = 1'b1;
    p0 = n_pulses;
    pulse_start();
    wait_pulses(p0 + 2, 100);
    repeat (2) step();
    check("mid_state", O_dbg_state, ST_WAIT_DONE);
    I_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    addr_q.delete();
    step();
    I_rst_n = 1'b1;
    repeat (5) step();
    check("mid_no_done", n_done, exp_done);
    push_frame(1'b0);
    I_extra_bit = 1'b0;
    pulse_start();
    exp_done++;
    wait_idle(500);
    check_frames_clean("after_rst");

    // Randomized frames.
    fixed_busy = 1'b0;
    for (int r = 0; r < 6; r++) begin
      e = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) step();
      push_frame(e);
      I_extra_bit = e;
      pulse_start();
      exp_done++;
      wait_idle(500);
      check("rand_extra", O_extra_bit, e);
    end
    check_frames_clean("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_scan_sequencer.md
# matrix_scan_sequencer

Frame-scan controller that drives the LED-matrix output module (SPI transmitter plus column-select shift register) from a synchronous frame buffer. It walks one frame column by column and word by word. For each word it reads the buffer, presents the data, and issues the next-image, next-column or next-data command pulse. It then tracks the output module's transmit-finish handshake before advancing. It sits between the frame buffer / HDMI capture side and the output module.

## Interface
Parameters:
- COLUMNS, 16, matrix columns per frame (≥1)
- WORDS_PER_COLUMN, 8, SPI words per column (≥1)
- CHANNEL_NUMBER, 3, parallel SPI channels
- SPI_SIZE, 8, bits per SPI word per channel
- ADDR_WIDTH, $clog2(COLUMNS*WORDS_PER_COLUMN) (min 1), buffer address width

Ports:
- I_clk  in  1  system clock; all logic on its rising edge
- I_rst_n  in  1  asynchronous, active-low reset
- I_start  in  1  one-cycle request to scan one frame
- I_continuous  in  1  when high, restart the scan automatically at frame end
- I_extra_bit  in  1  column-select extra bit, latched at frame start
- O_rd_en  out  1  frame-buffer read strobe
- O_rd_addr  out  ADDR_WIDTH  frame-buffer word address
- I_rd_data  in  SPI_SIZE*CHANNEL_NUMBER  read data, valid exactly 1 cycle after O_rd_en
- O_data_flat  out  SPI_SIZE*CHANNEL_NUMBER  word presented to the output module
- O_next_image  out  1  command pulse: select first column, then transmit
- O_next_column  out  1  command pulse: shift to next column, then transmit
- O_next_data  out  1  command pulse: transmit only
- O_extra_bit  out  1  latched extra bit
- I_tx_finish  in  1  output module idle/ready (high = idle)
- O_busy  out  1  high in every state except IDLE
- O_frame_done  out  1  one-cycle pulse after the last word of a frame completes

## Operation
- Counters:
  - col: 0..COLUMNS-1.
  - word: 0..WORDS_PER_COLUMN-1.
  - O_rd_addr is a linear counter equal to col*WORDS_PER_COLUMN+word. It increments by 1 per word and wraps to 0 at frame end. No multiplier is used.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_BUSY, WAIT_DONE, FRAME_END.
- IDLE:
  - Outputs quiescent.
  - When I_start=1 and I_tx_finish=1: latch I_extra_bit into O_extra_bit, clear col, word and addr, then go to FETCH.
  - I_start with I_tx_finish=0 is dropped; there is no queueing.
- FETCH: O_rd_en=1 with the current addr → LATCH.
- LATCH: register I_rd_data into O_data_flat → ISSUE.
- ISSUE: assert exactly one command for one cycle → WAIT_BUSY.
  - col=0, word=0: O_next_image.
  - col>0, word=0: O_next_column.
  - word>0: O_next_data.
- WAIT_BUSY: wait for I_tx_finish=0 → WAIT_DONE.
- WAIT_DONE: wait for I_tx_finish=1, then advance.
  - Not the last word of the frame: increment word; at WORDS_PER_COLUMN-1, wrap word to 0 and increment col. Increment addr. Go to FETCH.
  - Last word (col=COLUMNS-1, word=WORDS_PER_COLUMN-1): go to FRAME_END.
- FRAME_END: O_frame_done=1 for this cycle; clear col, word and addr.
  - If I_continuous=1: re-latch I_extra_bit and go to FETCH.
  - Otherwise go to IDLE.
- O_data_flat holds its value from LATCH until the next LATCH. It is therefore stable for the whole transmission.
- I_start outside IDLE is ignored. I_continuous is sampled only in FRAME_END.
- Undefined state encodings recover to IDLE.

## Timing
- Reset (asynchronous assert, synchronous release by I_clk): state=IDLE, all counters 0, O_rd_en=0, O_rd_addr=0, O_data_flat=0, all command pulses 0, O_extra_bit=0, O_busy=0, O_frame_done=0.
- All outputs are registered or decoded from the state register; none depend combinationally on inputs.
- I_start accepted at edge N: FETCH in cycle N+1, LATCH in N+2, command pulse in N+3.
- Fixed overhead per word: 3 cycles (FETCH, LATCH, ISSUE) plus the output module's busy time plus 1 cycle of WAIT_DONE detection.
- Commands are issued only after I_tx_finish has been seen 0 then 1. A module that never drops I_tx_finish holds the sequencer in WAIT_BUSY indefinitely; this is by design, with no timeout.
- Reset asserted mid-frame aborts immediately:
  - Command pulses drop in the same cycle.
  - No O_frame_done is generated.
  - The next frame requires a new I_start.

## Test plan
- Setup for all scenarios: COLUMNS=2, WORDS_PER_COLUMN=2, buffer content addr k = 0x10+k per channel, output-module model busy for 5 cycles.
- Single frame, I_start pulse:
  - Commands in order image, data, column, data.
  - O_rd_addr sequence 0,1,2,3; O_data_flat 0x10..0x13 at each pulse.
  - One O_frame_done pulse, then O_busy=0.
- Latency and handshake: first command exactly 3 cycles after I_start. Holding I_tx_finish=1 indefinitely after a pulse → state stays WAIT_BUSY and no further pulses are issued.
- I_continuous=1: after addr 3, O_frame_done pulses and the next command is O_next_image with data 0x10. Drop I_continuous → stops after the following frame.
- I_start while busy or with I_tx_finish=0 in IDLE → ignored; no second frame starts.
- Extra bit: I_extra_bit=1 at start, then 0 mid-frame → O_extra_bit stays 1 for the whole frame.
- Reset during WAIT_DONE of word 2 → all outputs return to reset values at once. The next I_start begins again at addr 0 with O_next_image.
